// File: rtl/inst_mem_server_if.sv
// Fetch and loader signal bundle for inst_mem_server.
// fetch_err exists only when INST_MEM_OOR_ERR_EN is defined.
interface inst_mem_server_if #(
    parameter int ADDR_W = 10
);
    logic              load_start;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_end;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [31:0]       fetch_data;
`ifdef INST_MEM_OOR_ERR_EN
    logic              fetch_err;

    modport master (
        output load_start, load_valid, load_byte, load_end, fetch_req, fetch_addr,
        input  load_ready, load_done, load_count, fetch_ready, fetch_valid, fetch_data,
               fetch_err
    );
    modport slave (
        input  load_start, load_valid, load_byte, load_end, fetch_req, fetch_addr,
        output load_ready, load_done, load_count, fetch_ready, fetch_valid, fetch_data,
               fetch_err
    );
`else
    modport master (
        output load_start, load_valid, load_byte, load_end, fetch_req, fetch_addr,
        input  load_ready, load_done, load_count, fetch_ready, fetch_valid, fetch_data
    );
    modport slave (
        input  load_start, load_valid, load_byte, load_end, fetch_req, fetch_addr,
        output load_ready, load_done, load_count, fetch_ready, fetch_valid, fetch_data
    );
`endif
endinterface

// File: rtl/inst_mem_server.sv
// Instruction RAM with a 1-cycle fetch port and a serial byte loader (MSB first).
// Define INST_MEM_OOR_ERR_EN to add fetch_err for out-of-range fetches.
module inst_mem_server #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    inst_mem_server_if.slave  bus
);
    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [1:0]        byte_cnt;
    logic [31:0]       acc;
    logic [31:0]       mem [DEPTH];

    logic        in_load;
    logic        byte_acc;
    logic        do_write;
    logic        finish;
    logic        fetch_acc;
    logic        addr_oor;
    logic [31:0] acc_next;

    assign in_load   = (state == LOAD);
    assign byte_acc  = in_load && bus.load_valid && !bus.load_start;
    // A same-cycle byte joins the final word before load_end closes it.
    assign do_write  = in_load && !bus.load_start &&
                       ((byte_acc && byte_cnt == 2'd3) ||
                        (bus.load_end && (byte_cnt != 2'd0 || byte_acc)));
    assign finish    = in_load && !bus.load_start &&
                       (bus.load_end || (do_write && ptr == LAST_PTR));
    assign fetch_acc = !in_load && bus.fetch_req && !bus.load_start;
    assign addr_oor  = ({1'b0, bus.fetch_addr} >= DEPTH_W);

    always_comb begin
        acc_next = acc;
        if (byte_acc) begin
            case (byte_cnt)
                2'd0:    acc_next[31:24] = bus.load_byte;
                2'd1:    acc_next[23:16] = bus.load_byte;
                2'd2:    acc_next[15:8]  = bus.load_byte;
                default: acc_next[7:0]   = bus.load_byte;
            endcase
        end
    end

    // RAM has no reset so it maps onto block memory and survives reset.
    always_ff @(posedge CLOCK_50) begin
        if (do_write)
            mem[ptr[IDX_W-1:0]] <= acc_next;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            bus.load_ready  <= 1'b0;
            bus.fetch_ready <= 1'b1;
            bus.load_done   <= 1'b0;
            bus.load_count  <= '0;
            bus.fetch_valid <= 1'b0;
            bus.fetch_data  <= '0;
`ifdef INST_MEM_OOR_ERR_EN
            bus.fetch_err   <= 1'b0;
`endif
            ptr             <= '0;
            byte_cnt        <= '0;
            acc             <= '0;
        end else begin
            bus.load_done   <= 1'b0;
            bus.fetch_valid <= fetch_acc;
`ifdef INST_MEM_OOR_ERR_EN
            bus.fetch_err   <= fetch_acc && addr_oor;
`endif
            if (fetch_acc)
                bus.fetch_data <= addr_oor ? 32'h0000_0000 : mem[bus.fetch_addr[IDX_W-1:0]];

            if (bus.load_start) begin
                // Start or restart; words already written stay in RAM.
                state           <= LOAD;
                bus.load_ready  <= 1'b1;
                bus.fetch_ready <= 1'b0;
                ptr             <= '0;
                byte_cnt        <= '0;
                acc             <= '0;
                bus.load_count  <= '0;
            end else if (in_load) begin
                if (do_write) begin
                    ptr            <= ptr + 1'b1;
                    bus.load_count <= bus.load_count + 1'b1;
                    byte_cnt       <= '0;
                    acc            <= '0;
                end else if (byte_acc) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    acc      <= acc_next;
                end
                if (finish) begin
                    state           <= IDLE;
                    bus.load_ready  <= 1'b0;
                    bus.fetch_ready <= 1'b1;
                    bus.load_done   <= 1'b1;
                    byte_cnt        <= '0;
                    acc             <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_mem_server.sv
// Directed bench for inst_mem_server (DEPTH = 16): fetch table plus load/reset sequences.
module tb_inst_mem_server;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 16;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   n_vec    = 0;
    int   n_err    = 0;

    inst_mem_server_if #(.ADDR_W(ADDR_W)) bus ();

    inst_mem_server #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              err;
    } fvec_t;

    fvec_t tbl [7];

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic end_load();
        bus.load_end = 1'b1;
        tick();
        bus.load_end = 1'b0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string name);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        tick();
        bus.fetch_req  = 1'b0;
        check({name, "_valid"}, 32'(bus.fetch_valid), 32'd1);
        check({name, "_data"}, bus.fetch_data, exp);
    endtask

    initial begin
        tbl[0] = '{addr: 10'd0,    data: 32'h0001_0203, err: 1'b0};
        tbl[1] = '{addr: 10'd5,    data: 32'h1415_1617, err: 1'b0};
        tbl[2] = '{addr: 10'd15,   data: 32'h3C3D_3E3F, err: 1'b0};
        tbl[3] = '{addr: 10'd16,   data: 32'h0000_0000, err: 1'b1};
        tbl[4] = '{addr: 10'd7,    data: 32'h1C1D_1E1F, err: 1'b0};
        tbl[5] = '{addr: 10'd20,   data: 32'h0000_0000, err: 1'b1};
        tbl[6] = '{addr: 10'd1023, data: 32'h0000_0000, err: 1'b1};

        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_byte  = 8'h00;
        bus.load_end   = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;

        #12;
        check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
        check("rst_load_ready",  32'(bus.load_ready),  32'd0);
        check("rst_load_count",  32'(bus.load_count),  32'd0);
        check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("rst_fetch_data",  bus.fetch_data,       32'd0);
        check("rst_load_done",   32'(bus.load_done),   32'd0);
        reset = 1'b0;
        tick();

        // Two full words, then load_end on a word boundary
        start_load();
        check("ld1_ready", 32'(bus.load_ready), 32'd1);
        check("ld1_fready", 32'(bus.fetch_ready), 32'd0);
        foreach (tbl[i]) begin end
        put_byte(8'h01); put_byte(8'h02); put_byte(8'h03); put_byte(8'h04);
        put_byte(8'hAA); put_byte(8'hBB); put_byte(8'hCC); put_byte(8'hDD);
        check("ld1_count", 32'(bus.load_count), 32'd2);
        end_load();
        check("ld1_done", 32'(bus.load_done), 32'd1);
        check("ld1_count_end", 32'(bus.load_count), 32'd2);
        tick();
        check("ld1_done_pulse", 32'(bus.load_done), 32'd0);
        fetch(10'd0, 32'h0102_0304, "f0");
        tick();
        fetch(10'd1, 32'hAABB_CCDD, "f1");
        tick();

        // Back-to-back fetches 0,1,0
        bus.fetch_req = 1'b1;
        bus.fetch_addr = 10'd0; tick();
        check("b2b0_valid", 32'(bus.fetch_valid), 32'd1);
        check("b2b0_data", bus.fetch_data, 32'h0102_0304);
        bus.fetch_addr = 10'd1; tick();
        check("b2b1_valid", 32'(bus.fetch_valid), 32'd1);
        check("b2b1_data", bus.fetch_data, 32'hAABB_CCDD);
        bus.fetch_addr = 10'd0; tick();
        check("b2b2_valid", 32'(bus.fetch_valid), 32'd1);
        check("b2b2_data", bus.fetch_data, 32'h0102_0304);
        bus.fetch_req = 1'b0; tick();
        check("hold_valid", 32'(bus.fetch_valid), 32'd0);
        check("hold_data", bus.fetch_data, 32'h0102_0304);

        // Fetch request held through a load is served only afterwards
        start_load();
        bus.fetch_req = 1'b1; bus.fetch_addr = 10'd1;
        tick();
        check("blk_fready", 32'(bus.fetch_ready), 32'd0);
        check("blk_valid0", 32'(bus.fetch_valid), 32'd0);
        put_byte(8'hDE); put_byte(8'hAD); put_byte(8'hBE); put_byte(8'hEF);
        check("blk_valid1", 32'(bus.fetch_valid), 32'd0);
        end_load();
        check("blk_done", 32'(bus.load_done), 32'd1);
        check("blk_valid2", 32'(bus.fetch_valid), 32'd0);
        tick();
        bus.fetch_req = 1'b0;
        check("blk_served_valid", 32'(bus.fetch_valid), 32'd1);
        check("blk_served_data", bus.fetch_data, 32'hAABB_CCDD);
        tick();
        fetch(10'd0, 32'hDEAD_BEEF, "blk_w0");
        tick();

        // Partial word padded with zeros
        start_load();
        put_byte(8'h12); put_byte(8'h34);
        check("part_count0", 32'(bus.load_count), 32'd0);
        end_load();
        check("part_done", 32'(bus.load_done), 32'd1);
        check("part_count", 32'(bus.load_count), 32'd1);
        tick();
        check("part_done_pulse", 32'(bus.load_done), 32'd0);
        fetch(10'd0, 32'h1234_0000, "part_w0");
        tick();
        fetch(10'd1, 32'hAABB_CCDD, "part_w1");
        tick();

        // load_end together with the last byte
        start_load();
        put_byte(8'h56);
        bus.load_valid = 1'b1; bus.load_byte = 8'h78; bus.load_end = 1'b1;
        tick();
        bus.load_valid = 1'b0; bus.load_end = 1'b0;
        check("endb_done", 32'(bus.load_done), 32'd1);
        check("endb_count", 32'(bus.load_count), 32'd1);
        tick();
        fetch(10'd0, 32'h5678_0000, "endb_w0");
        tick();

        // load_start beats a same-cycle fetch, then fill all DEPTH words
        bus.load_start = 1'b1; bus.fetch_req = 1'b1; bus.fetch_addr = 10'd1;
        tick();
        bus.load_start = 1'b0; bus.fetch_req = 1'b0;
        check("prio_valid", 32'(bus.fetch_valid), 32'd0);
        check("prio_lready", 32'(bus.load_ready), 32'd1);
        for (int i = 0; i < 4*DEPTH - 1; i++) put_byte(8'(i));
        check("full_ready63", 32'(bus.load_ready), 32'd1);
        check("full_count63", 32'(bus.load_count), 32'd15);
        put_byte(8'd63);
        check("full_ready", 32'(bus.load_ready), 32'd0);
        check("full_done", 32'(bus.load_done), 32'd1);
        check("full_count", 32'(bus.load_count), 32'd16);
        put_byte(8'hFF);
        check("full_extra_count", 32'(bus.load_count), 32'd16);
        check("full_extra_done", 32'(bus.load_done), 32'd0);

        for (int i = 0; i < 7; i++) begin
            fetch(tbl[i].addr, tbl[i].data, $sformatf("tbl%0d", i));
`ifdef INST_MEM_OOR_ERR_EN
            check($sformatf("tbl%0d_err", i), 32'(bus.fetch_err), 32'(tbl[i].err));
`endif
            tick();
        end

        // Reset in the middle of a load
        start_load();
        for (int i = 0; i < 7; i++) put_byte(8'hA0 + 8'(i));
        check("rml_count_pre", 32'(bus.load_count), 32'd1);
        reset = 1'b1;
        #1;
        check("rml_lready", 32'(bus.load_ready), 32'd0);
        check("rml_count", 32'(bus.load_count), 32'd0);
        check("rml_fready", 32'(bus.fetch_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        start_load();
        put_byte(8'h11); put_byte(8'h22); put_byte(8'h33); put_byte(8'h44);
        end_load();
        check("rml_new_count", 32'(bus.load_count), 32'd1);
        tick();
        fetch(10'd0, 32'h1122_3344, "rml_w0");
        tick();
        fetch(10'd1, 32'h0405_0607, "rml_w1");

        // Reset while a response is on the port drops it
        reset = 1'b1;
        #1;
        check("rmf_valid", 32'(bus.fetch_valid), 32'd0);
        check("rmf_data", bus.fetch_data, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule

// File: doc/inst_mem_server.md
Name: inst_mem_server

Overview:
- Instruction-memory endpoint facing the CPU fetch stage.
- Serves 32-bit instruction words on a request/response fetch port with 1-cycle latency.
- Also accepts a serial byte stream from a host-side loader, assembles the bytes into words and writes them into the internal RAM, so programs can be replaced without re-synthesis.
- Sits between the board-level loader (switch/UART byte source) and the CPU fetch logic.

Parameters:
- ADDR_W, 10, fetch/load word-address width.
- DEPTH, 1024, number of 32-bit words in the RAM; must be ≤ 2^ADDR_W.

Ports:
- CLOCK_50  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  pulse: begin a new program load at word 0.
- load_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  program byte, most-significant byte of each word first.
- load_end  in  1  pulse: terminate the load early.
- load_ready  out  1  high while in LOAD; a byte is accepted when load_valid && load_ready.
- load_done  out  1  one-cycle pulse when a load completes.
- load_count  out  ADDR_W+1  number of words written by the last or current load.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  word address.
- fetch_ready  out  1  high when requests are accepted (IDLE only).
- fetch_valid  out  1  response strobe.
- fetch_data  out  32  instruction word.

Behaviour:
- Reset (async):
  - state = IDLE; load_ready = 0; load_done = 0; load_count = 0.
  - fetch_valid = 0; fetch_data = 0; internal byte counter and assembly register = 0.
  - RAM contents are not cleared.
- States: IDLE, LOAD.
- IDLE:
  - fetch_ready = 1, load_ready = 0.
  - load_start moves to LOAD: pointer = 0, byte_cnt = 0, load_count = 0.
  - load_start has priority over a same-cycle fetch_req; that request is not accepted.
- LOAD:
  - fetch_ready = 0, load_ready = 1. fetch_req is ignored; fetch_valid stays 0.
  - Each accepted byte shifts into the assembly register:
    - byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - On the 4th byte: the word is written at the pointer in the same edge, the pointer increments, load_count increments and byte_cnt wraps to 0.
  - Write at pointer DEPTH-1: state returns to IDLE and load_done pulses on the next cycle. Further bytes are not accepted.
  - load_end with byte_cnt == 0: return to IDLE, load_done pulse, no write.
  - load_end with a partial word: unfilled low bytes are padded with 0x00, the word is written, load_count increments, then IDLE with a load_done pulse.
  - load_end and load_valid in the same cycle: the byte is accepted first and included in the final (possibly padded) word.
  - load_start during LOAD: restart. The partial word is discarded, pointer = 0 and load_count = 0; already-written words are not erased.
- Fetch:
  - A request is accepted when fetch_req && fetch_ready.
  - fetch_valid is high exactly one cycle later, with fetch_data = RAM[fetch_addr].
  - Back-to-back requests give back-to-back responses.
  - fetch_data holds its last value while fetch_valid = 0.
  - fetch_addr ≥ DEPTH returns 0x00000000 (MIPS NOP).
  - RAM read and RAM write never occur in the same cycle.
- Reset mid-load or mid-fetch: immediate return to the reset values. A pending response is dropped.

Optional Feature:
- Macro INST_MEM_OOR_ERR_EN.
- When defined:
  - An extra output fetch_err (1 bit, reset 0) is added.
  - fetch_err is high alongside fetch_valid when the accepted fetch_addr ≥ DEPTH, and low otherwise.
  - Loader bytes arriving after the DEPTH-th word are also impossible, because load_ready is already 0.
- When undefined: no fetch_err port; out-of-range fetches silently return NOP.

Test Plan:
- Load and fetch: load_start, then bytes 01 02 03 04 AA BB CC DD. Required: load_count = 2 and a load_done pulse. Fetch addr 0 gives 0x01020304 one cycle later; fetch addr 1 gives 0xAABBCCDD.
- Partial word: load_start, bytes 12 34, then load_end. Required: RAM[0] = 0x12340000, load_count = 1, one load_done pulse.
- Back-to-back fetch with addresses 0, 1, 0 on consecutive cycles. Required: fetch_valid high for 3 consecutive cycles with data 0x01020304, 0xAABBCCDD, 0x01020304.
- Fetch blocked during load: fetch_req during LOAD. Required: fetch_ready = 0 and no fetch_valid. The same request after load_done is served.
- Out of range, with DEPTH = 16: fetch addr 20 gives fetch_data 0x00000000, plus fetch_err = 1 if INST_MEM_OOR_ERR_EN is defined. Loading 64 bytes ends with load_count = 16 and load_ready dropping after the 64th byte.
- Reset mid-load: assert reset after 3 bytes. Required: load_ready = 0, load_count = 0, state IDLE immediately. A new load then writes word 0 correctly.
